// File: rtl/krz_perif_pkg.sv
// Shared types and address-map constants for the peripheral bus.
package krz_perif_pkg;

  localparam int PERIF_SLOT_LSB  = 8;
  localparam int PERIF_SLOT_MSB  = 11;
  localparam int PERIF_MAX_SLOTS = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } perif_state_e;

endpackage

// File: rtl/krz_perif_timeout.sv
// Saturating strobe-cycle counter; expired_o flags the last cycle an access may wait.
module krz_perif_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int MAX_I  = (TIMEOUT > 0) ? TIMEOUT : 0;
  localparam logic [W-1:0] LAST = LAST_I[W-1:0];
  localparam logic [W-1:0] MAX  = MAX_I[W-1:0];

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero TIMEOUT means accesses may wait forever.
  assign expired_o = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/krz_perif_bus.sv
// Wishbone classic bridge from the crossbar onto up to 16 peripheral slots,
// with registered ACK and ERR for unmapped slots or timed-out peripherals.
module krz_perif_bus
  import krz_perif_pkg::*;
#(
  parameter int N       = 4,
  parameter int PAW     = 6,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [23:0]     sys_adr_i,
  input  logic [31:0]     sys_dat_i,
  input  logic [3:0]      sys_sel_i,
  input  logic            sys_we_i,
  input  logic            sys_stb_i,
  output logic [31:0]     sys_dat_o,
  output logic            sys_ack_o,
  output logic            sys_err_o,
  output logic [PAW-1:0]  perif_adr_o,
  output logic [31:0]     perif_dat_o,
  output logic [3:0]      perif_sel_o,
  output logic            perif_we_o,
  output logic [N-1:0]    perif_stb_o,
  input  logic [N*32-1:0] perif_dat_i,
  input  logic [N-1:0]    perif_ack_i
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam logic [4:0] N5 = 5'(N);

  perif_state_e   state_q, state_d;
  logic [SW-1:0]  slot_q, slot_d;
  logic [PAW-1:0] adr_q, adr_d;
  logic [31:0]    wdat_q, wdat_d;
  logic [3:0]     sel_q, sel_d;
  logic           we_q, we_d;
  logic [N-1:0]   stb_q, stb_d;
  logic [31:0]    rdat_q, rdat_d;
  logic           ack_q, ack_d;
  logic           err_q, err_d;

  logic [3:0]  slot;
  logic        mapped;
  logic        new_req;
  logic        slot_ack;
  logic [31:0] slot_dat;
  logic        tmr_clear;
  logic        tmr_en;
  logic        tmr_expired;
  logic        adr_unused;

  assign slot     = sys_adr_i[PERIF_SLOT_MSB:PERIF_SLOT_LSB];
  assign mapped   = ({1'b0, slot} < N5);
  assign new_req  = sys_stb_i && !ack_q && !err_q;
  // Only the slot that was strobed is listened to; other slots are masked out.
  assign slot_ack = perif_ack_i[slot_q];
  assign slot_dat = perif_dat_i[{slot_q, 5'b0} +: 32];
  assign adr_unused = ^sys_adr_i;

  krz_perif_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (tmr_clear),
    .enable_i (tmr_en),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    stb_d     = stb_q;
    rdat_d    = rdat_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (new_req) begin
          if (mapped) begin
            slot_d    = slot[SW-1:0];
            adr_d     = sys_adr_i[PAW+1:2];
            wdat_d    = sys_dat_i;
            sel_d     = sys_sel_i;
            we_d      = sys_we_i;
            stb_d     = N'(1) << slot;
            tmr_clear = 1'b1;
            state_d   = ACCESS;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        // An ACK arriving in the expiry cycle still counts as success.
        if (slot_ack) begin
          stb_d   = '0;
          rdat_d  = slot_dat;
          ack_d   = 1'b1;
          state_d = RESP;
        end else if (tmr_expired) begin
          stb_d   = '0;
          rdat_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmr_en = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      stb_q   <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      stb_q   <= stb_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign sys_dat_o   = rdat_q;
  assign sys_ack_o   = ack_q;
  assign sys_err_o   = err_q;
  assign perif_adr_o = adr_q;
  assign perif_dat_o = wdat_q;
  assign perif_sel_o = sel_q;
  assign perif_we_o  = we_q;
  assign perif_stb_o = stb_q;

endmodule

// File: tb/tb_krz_perif_bus.sv
// Directed scoreboard bench for krz_perif_bus (N=4, PAW=6, TIMEOUT=8).
module tb_krz_perif_bus;

  localparam int N       = 4;
  localparam int PAW     = 6;
  localparam int TIMEOUT = 8;

  logic            clk;
  logic            rst;
  logic [23:0]     sys_adr_i;
  logic [31:0]     sys_dat_i;
  logic [3:0]      sys_sel_i;
  logic            sys_we_i;
  logic            sys_stb_i;
  logic [31:0]     sys_dat_o;
  logic            sys_ack_o;
  logic            sys_err_o;
  logic [PAW-1:0]  perif_adr_o;
  logic [31:0]     perif_dat_o;
  logic [3:0]      perif_sel_o;
  logic            perif_we_o;
  logic [N-1:0]    perif_stb_o;
  logic [N*32-1:0] perif_dat_i;
  logic [N-1:0]    perif_ack_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit          err;
    logic [31:0] data;
    int          cycle;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];
  exp_t  monE;
  string monName;

  krz_perif_bus #(
    .N(N),
    .PAW(PAW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sys_adr_i  (sys_adr_i),
    .sys_dat_i  (sys_dat_i),
    .sys_sel_i  (sys_sel_i),
    .sys_we_i   (sys_we_i),
    .sys_stb_i  (sys_stb_i),
    .sys_dat_o  (sys_dat_o),
    .sys_ack_o  (sys_ack_o),
    .sys_err_o  (sys_err_o),
    .perif_adr_o(perif_adr_o),
    .perif_dat_o(perif_dat_o),
    .perif_sel_o(perif_sel_o),
    .perif_we_o (perif_we_o),
    .perif_stb_o(perif_stb_o),
    .perif_dat_i(perif_dat_i),
    .perif_ack_i(perif_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every response the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (sys_ack_o || sys_err_o) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_response: ack=%0b err=%0b, expected no response", sys_ack_o, sys_err_o);
      end else begin
        monE    = expQ.pop_front();
        monName = nameQ.pop_front();
        checkOutput({monName, " err"}, {31'b0, sys_err_o}, {31'b0, monE.err});
        checkOutput({monName, " ack"}, {31'b0, sys_ack_o}, {31'b0, !monE.err});
        checkOutput({monName, " data"}, sys_dat_o, monE.data);
        checkOutput({monName, " cycle"}, cyc, monE.cycle);
      end
    end
  end

  task automatic applyStimulus(
    input string       name,
    input logic [23:0] adr,
    input logic [31:0] dat,
    input logic [3:0]  sel,
    input logic        we,
    input logic [3:0]  expStb,
    input logic [5:0]  expAdr,
    input int          ackK,
    input int          spurK,
    input bit          expErr,
    input logic [31:0] expData,
    input int          expLat,
    input int          expStbCycles
  );
    int stbCycles = 0;
    bit done = 0;
    @(posedge clk); #1;
    sys_adr_i = adr;
    sys_dat_i = dat;
    sys_sel_i = sel;
    sys_we_i  = we;
    sys_stb_i = 1'b1;
    expQ.push_back('{expErr, expData, cyc + expLat});
    nameQ.push_back(name);
    for (int j = 1; j <= 40 && !done; j++) begin
      @(posedge clk); #1;
      perif_ack_i = '0;
      if (sys_ack_o || sys_err_o) begin
        checkOutput({name, " stb_at_resp"}, {28'b0, perif_stb_o}, 32'h0);
        sys_stb_i = 1'b0;
        done = 1;
      end else begin
        checkOutput({name, " stb"}, {28'b0, perif_stb_o}, {28'b0, expStb});
        if (perif_stb_o != '0) stbCycles++;
        if (j == 1 && expStb != '0) begin
          checkOutput({name, " perif_adr"}, {26'b0, perif_adr_o}, {26'b0, expAdr});
          checkOutput({name, " perif_dat"}, perif_dat_o, dat);
          checkOutput({name, " perif_sel"}, {28'b0, perif_sel_o}, {28'b0, sel});
          checkOutput({name, " perif_we"}, {31'b0, perif_we_o}, {31'b0, we});
        end
        if (ackK >= 0 && j == 1 + ackK) perif_ack_i = perif_ack_i | expStb;
        if (spurK >= 0 && j == 1 + spurK) perif_ack_i = perif_ack_i | 4'b0001;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s no_response: got none in 40 cycles, expected one", name);
      sys_stb_i = 1'b0;
      perif_ack_i = '0;
    end
    checkOutput({name, " stb_cycles"}, stbCycles, expStbCycles);
    if (expStb != '0) begin
      checkOutput({name, " adr_held"}, {26'b0, perif_adr_o}, {26'b0, expAdr});
    end
  endtask

  initial begin
    rst         = 1'b1;
    sys_adr_i   = '0;
    sys_dat_i   = '0;
    sys_sel_i   = '0;
    sys_we_i    = 1'b0;
    sys_stb_i   = 1'b0;
    perif_ack_i = '0;
    perif_dat_i = {32'h33333333, 32'hCAFE0001, 32'h11111111, 32'h00005A5A};
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset stb", {28'b0, perif_stb_o}, 32'h0);
    checkOutput("reset ack", {31'b0, sys_ack_o}, 32'h0);
    checkOutput("reset err", {31'b0, sys_err_o}, 32'h0);
    checkOutput("reset dat", sys_dat_o, 32'h0);
    checkOutput("reset adr", {26'b0, perif_adr_o}, 32'h0);
    checkOutput("reset we", {31'b0, perif_we_o}, 32'h0);
    rst = 1'b0;

    applyStimulus("read_slot2", 24'h000204, 32'h0, 4'hF, 1'b0, 4'b0100, 6'd1,
                  3, -1, 1'b0, 32'hCAFE0001, 5, 4);
    applyStimulus("write_slot0", 24'h000010, 32'h12345678, 4'b0011, 1'b1, 4'b0001, 6'd4,
                  0, -1, 1'b0, 32'h00005A5A, 2, 1);
    applyStimulus("unmapped", 24'h000500, 32'hDEADBEEF, 4'hF, 1'b0, 4'b0000, 6'd0,
                  -1, -1, 1'b1, 32'h00005A5A, 1, 0);
    applyStimulus("timeout_slot1", 24'h000108, 32'h0, 4'hF, 1'b0, 4'b0010, 6'd2,
                  -1, -1, 1'b1, 32'h0, 9, 8);
    applyStimulus("spurious_slot3", 24'h00030C, 32'h0, 4'hF, 1'b0, 4'b1000, 6'd3,
                  7, 1, 1'b0, 32'h33333333, 9, 8);

    // Reset in the middle of an access must abort it without any response.
    @(posedge clk); #1;
    sys_adr_i = 24'h000208;
    sys_we_i  = 1'b0;
    sys_stb_i = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort stb_before", {28'b0, perif_stb_o}, 32'h4);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort stb", {28'b0, perif_stb_o}, 32'h0);
    checkOutput("abort ack", {31'b0, sys_ack_o}, 32'h0);
    checkOutput("abort err", {31'b0, sys_err_o}, 32'h0);
    sys_stb_i   = 1'b0;
    perif_ack_i = 4'b0100;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    perif_ack_i = '0;
    checkOutput("abort stb_after", {28'b0, perif_stb_o}, 32'h0);

    applyStimulus("fresh_slot1", 24'h000104, 32'h0, 4'hF, 1'b0, 4'b0010, 6'd1,
                  1, -1, 1'b0, 32'h11111111, 3, 2);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("pending_responses", expQ.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
